// File: rtl/bus_enc_pkg.sv
// Shared widths for the 32-to-5 bus-enable encoder.
// Default error-counter width lives here so top and bench agree.
package bus_enc_pkg;
  localparam int ENC_IN_W      = 32;
  localparam int ENC_OUT_W     = 5;
  localparam int ERR_CNT_W_DEF = 8;
endpackage

// File: rtl/bus_encoder_32_5_ffs.sv
// ffs_from_ptr: first set bit from a start index, wrapping.
// rev=1 searches downward (start 31 gives highest-index-wins).
module ffs_from_ptr
  import bus_enc_pkg::*;
#(
  parameter bit REV = 1'b0
) (
  input  logic [ENC_IN_W-1:0]  vec,
  input  logic [ENC_OUT_W-1:0] ptr,
  output logic                 found,
  output logic [ENC_OUT_W-1:0] idx
);

  logic [ENC_OUT_W-1:0] p;

  // Walk from the farthest offset to the nearest so the
  // nearest set bit is the last (winning) assignment.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    p     = '0;
    for (int k = ENC_IN_W - 1; k >= 0; k--) begin
      p = REV ? ptr - ENC_OUT_W'(k) : ptr + ENC_OUT_W'(k);
      if (vec[p]) begin
        found = 1'b1;
        idx   = p;
      end
    end
  end

endmodule

// File: rtl/bus_encoder_32_5.sv
// Registered 32-to-5 bus-enable encoder with multi-hot error tracking.
// Define BUS_ENC_ROUNDROBIN_EN for rotating priority instead of fixed.
module bus_encoder_32_5
  import bus_enc_pkg::*;
#(
  parameter int ERR_CNT_W = ERR_CNT_W_DEF
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic [ENC_IN_W-1:0]  encIn,
  input  logic                 enable,
  output logic [ENC_OUT_W-1:0] encOut,
  output logic                 encValid,
  output logic                 multiErr,
  output logic [ERR_CNT_W-1:0] errCount
);

  logic                 found;
  logic                 multi;
  logic [ENC_OUT_W-1:0] sel;
  logic [ENC_OUT_W-1:0] ptr;

  assign multi = |(encIn & (encIn - ENC_IN_W'(1)));

`ifdef BUS_ENC_ROUNDROBIN_EN
  ffs_from_ptr #(.REV(1'b0)) u_ffs (
    .vec   (encIn),
    .ptr   (ptr),
    .found (found),
    .idx   (sel)
  );

  always_ff @(posedge clock) begin
    if (clear)
      ptr <= '0;
    else if (enable && found)
      ptr <= sel + ENC_OUT_W'(1);
  end
`else
  assign ptr = ENC_OUT_W'(ENC_IN_W - 1);

  ffs_from_ptr #(.REV(1'b1)) u_ffs (
    .vec   (encIn),
    .ptr   (ptr),
    .found (found),
    .idx   (sel)
  );
`endif

  always_ff @(posedge clock) begin
    if (clear) begin
      encOut   <= '0;
      encValid <= 1'b0;
      multiErr <= 1'b0;
      errCount <= '0;
    end else begin
      encValid <= 1'b0;
      if (enable && found) begin
        encOut   <= sel;
        encValid <= 1'b1;
        if (multi) begin
          multiErr <= 1'b1;
          if (errCount != '1)
            errCount <= errCount + ERR_CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_encoder_32_5.sv
// Self-checking bench for bus_encoder_32_5 (table + scoreboard queue).
// Expected values are constants or derived from the stimulus here.
module tb_bus_encoder_32_5;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] encIn;
  logic        enable;
  logic [4:0]  encOut;
  logic        encValid;
  logic        multiErr;
  logic [7:0]  errCount;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          tag;
    logic        clr;
    logic        en;
    logic [31:0] in;
    logic [4:0]  out;
    logic        v;
    logic        m;
    logic [7:0]  cnt;
    logic        chk;
  } exp_t;

  exp_t sb[$];
  exp_t tbl[14];

  bus_encoder_32_5 #(.ERR_CNT_W(8)) dut (
    .clock    (clock),
    .clear    (clear),
    .encIn    (encIn),
    .enable   (enable),
    .encOut   (encOut),
    .encValid (encValid),
    .multiErr (multiErr),
    .errCount (errCount)
  );

  always #5 clock = ~clock;

  task automatic check();
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL sb_empty: no expectation queued");
      return;
    end
    e = sb.pop_front();
    if (encValid !== e.v || multiErr !== e.m ||
        errCount !== e.cnt || (e.chk && encOut !== e.out)) begin
      bad++;
      $display("FAIL step%0d: got out=%0d v=%0b m=%0b cnt=%0d want out=%0d v=%0b m=%0b cnt=%0d",
               e.tag, encOut, encValid, multiErr, errCount,
               e.out, e.v, e.m, e.cnt);
    end
  endtask

  task automatic apply(input exp_t e);
    @(negedge clock);
    clear  = e.clr;
    enable = e.en;
    encIn  = e.in;
    sb.push_back(e);
    @(posedge clock);
    #1;
    check();
  endtask

  function automatic exp_t mk(input int tag, input logic clr,
                              input logic en, input logic [31:0] in,
                              input logic [4:0] out, input logic v,
                              input logic m, input logic [7:0] cnt,
                              input logic chk);
    exp_t e;
    e.tag = tag; e.clr = clr; e.en = en; e.in = in;
    e.out = out; e.v = v; e.m = m; e.cnt = cnt; e.chk = chk;
    return e;
  endfunction

  initial begin
    int k;
    logic [7:0] c;
    clear  = 1'b1;
    enable = 1'b0;
    encIn  = '0;

    // reset value check, then fixed-priority table
    tbl[0]  = mk(0,  1, 0, 32'h0,         0,  0, 0, 0, 1);
    tbl[1]  = mk(1,  0, 1, 32'h0000_8000, 15, 1, 0, 0, 1);
    tbl[2]  = mk(2,  0, 1, 32'h8000_0001, 31, 1, 1, 1, 1);
    tbl[3]  = mk(3,  0, 1, 32'h0000_0002, 1,  1, 1, 1, 1);
    tbl[4]  = mk(4,  0, 1, 32'h0000_0080, 7,  1, 1, 1, 1);
    tbl[5]  = mk(5,  0, 1, 32'h0000_0000, 7,  0, 1, 1, 1);
    tbl[6]  = mk(6,  0, 0, 32'h0000_0010, 7,  0, 1, 1, 1);
    tbl[7]  = mk(7,  0, 1, 32'h0000_0001, 0,  1, 1, 1, 1);
    tbl[8]  = mk(8,  0, 1, 32'h0000_0001, 0,  1, 1, 1, 1);
    tbl[9]  = mk(9,  0, 1, 32'hFFFF_FFFF, 31, 1, 1, 2, 1);
    tbl[10] = mk(10, 0, 0, 32'hFFFF_FFFF, 31, 0, 1, 2, 1);
    tbl[11] = mk(11, 0, 1, 32'h0000_0006, 2,  1, 1, 3, 1);
    tbl[12] = mk(12, 0, 1, 32'h4000_0000, 30, 1, 1, 3, 1);
    tbl[13] = mk(13, 1, 1, 32'h0000_0004, 0,  0, 0, 0, 1);

    apply(tbl[0]);

`ifdef BUS_ENC_ROUNDROBIN_EN
    // rotating pointer: 0, 31, 0 while both ends stay set
    apply(mk(100, 0, 1, 32'h0000_8000, 15, 1, 0, 0, 1));
    apply(mk(101, 1, 0, 32'h0,          0, 0, 0, 0, 1));
    apply(mk(102, 0, 1, 32'h8000_0001,  0, 1, 1, 1, 1));
    apply(mk(103, 0, 1, 32'h8000_0001, 31, 1, 1, 2, 1));
    apply(mk(104, 0, 1, 32'h8000_0001,  0, 1, 1, 3, 1));
    apply(mk(105, 0, 1, 32'h0000_0080,  7, 1, 1, 3, 1));
    apply(mk(106, 0, 1, 32'h0000_0000,  7, 0, 1, 3, 1));
    apply(mk(107, 0, 0, 32'h0000_0010,  7, 0, 1, 3, 1));
    apply(tbl[13]);
`else
    for (int i = 1; i < 14; i++)
      apply(tbl[i]);
`endif

    // first sample after clear behaves as from power-up
    apply(mk(200, 0, 1, 32'h0000_0004, 2, 1, 0, 0, 1));
    apply(mk(201, 0, 0, 32'h0000_0004, 2, 0, 0, 0, 1));

    // saturation: 300 multi-hot samples, count stops at 255
    c = 8'd0;
    for (k = 0; k < 300; k++) begin
      if (c != 8'hFF)
        c = c + 8'd1;
`ifdef BUS_ENC_ROUNDROBIN_EN
      apply(mk(300 + k, 0, 1, 32'h0000_0003, 0, 1, 1, c, 0));
`else
      apply(mk(300 + k, 0, 1, 32'h0000_0003, 1, 1, 1, c, 1));
`endif
    end
    apply(mk(700, 0, 0, 32'h0000_0003, 0, 0, 1, 8'hFF, 0));
    apply(mk(701, 0, 1, 32'h0000_0100, 8, 1, 1, 8'hFF, 1));
    apply(mk(702, 0, 1, 32'h0000_0000, 8, 0, 1, 8'hFF, 1));
    apply(mk(703, 1, 0, 32'h0000_0000, 0, 0, 0, 8'h00, 1));

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bus_encoder_32_5.md
BUS_ENCODER_32_5 -- requirements
Module: bus_encoder_32_5

Interface
REQ-001 Parameter: ERR_CNT_W, default 8, width of the multi-hot error counter.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 Port: clock  input  1  rising-edge clock.
REQ-004 Port: clear  input  1  synchronous active-high reset.
REQ-005 Port: encIn  input  32  bus-driver out-enable lines, bit i = source i.
REQ-006 Port: enable  input  1  sample strobe; encIn is evaluated only when high.
REQ-007 Port: encOut  output  5  registered binary index of the selected source.
REQ-008 Port: encValid  output  1  single-cycle pulse marking a new encOut.
REQ-009 Port: multiErr  output  1  sticky flag, more than one encIn bit seen while sampling.
REQ-010 Port: errCount  output  ERR_CNT_W  saturating count of multi-hot samples.

Function
REQ-011 Latency SHALL be one cycle: a sample at edge N drives encOut/encValid from edge N until edge N+1.
REQ-012 enable=1, encIn one-hot at bit i: encOut SHALL be i and encValid SHALL be 1 for one cycle.
REQ-013 enable=1, encIn=0: encValid SHALL be 0; encOut SHALL hold its previous value.
REQ-014 enable=0: encValid SHALL be 0; encOut, multiErr, errCount and the priority pointer SHALL hold.
REQ-015 enable=1, two or more bits set: the single bit chosen by the active priority scheme (REQ-024/025) SHALL be encoded; encValid=1; multiErr SHALL be set.
REQ-016 Each multi-hot sample SHALL increment errCount by 1; at all-ones it SHALL saturate, with no wrap.
REQ-017 multiErr SHALL clear only on clear; a later one-hot sample SHALL NOT clear it.
REQ-018 encValid SHALL NOT stay high two cycles unless enable is high with nonzero encIn on consecutive edges.
REQ-019 Outputs SHALL depend only on registered state; no combinational path from encIn to any output.

Reset
REQ-020 clear=1 at a rising edge SHALL set encOut=0, encValid=0, multiErr=0, errCount=0 and priority pointer=0.
REQ-021 clear SHALL take precedence over enable in the same cycle; that cycle's sample SHALL be discarded.
REQ-022 After clear deasserts, the first enabled sample SHALL behave exactly as after power-up.
REQ-023 Before the first clear, outputs SHALL be unspecified.

Configuration
REQ-024 Without BUS_ENC_ROUNDROBIN_EN: fixed priority SHALL apply; the highest set index wins; no pointer state exists.
REQ-025 With BUS_ENC_ROUNDROBIN_EN: a 5-bit pointer SHALL select the first set bit at index >= pointer, searching upward and wrapping 31->0.
REQ-026 With BUS_ENC_ROUNDROBIN_EN: after each encValid sample the pointer SHALL become (selected index + 1) mod 32; it SHALL hold otherwise.
REQ-027 The one-hot and zero cases (REQ-012/013) SHALL be identical in both builds.

Structure
REQ-028 Package bus_enc_pkg SHALL hold ENC_IN_W=32, ENC_OUT_W=5 and the default ERR_CNT_W.
REQ-029 One sub-module, ffs_from_ptr, SHALL hold the combinational first-set search from a start index with wrap.
REQ-030 The fixed-priority build SHALL use ffs_from_ptr with a reversed search, or inline logic; the top level owns all registers.

Verification
REQ-031 Scenario: clear, then enable with encIn=32'h0000_8000 -> next cycle encOut=15, encValid=1, multiErr=0, errCount=0.
REQ-032 Scenario: enable with encIn=32'h8000_0001, fixed build -> encOut=31, multiErr=1, errCount=1; then one-hot 32'h2 -> encOut=1 and multiErr stays 1.
REQ-033 Scenario: round-robin build, encIn=32'h8000_0001 held with enable for 3 cycles -> encOut sequence 0, 31, 0.
REQ-034 Scenario: enable=1, encIn=0 after encOut=7 -> encValid=0 and encOut stays 7; enable=0 with encIn=32'h10 -> no change.
REQ-035 Scenario: 300 consecutive multi-hot samples with ERR_CNT_W=8 -> errCount=255 and holds.
REQ-036 Scenario: clear and enable both high with encIn=32'h4 -> all outputs 0; next enabled sample of 32'h4 -> encOut=2, encValid=1.
